// File: rtl/riscv_boot_sequencer_if.sv
// riscv_boot_sequencer_if: byte-stream ingress handshake and instruction-memory programming bus
interface riscv_boot_sequencer_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        prog_en;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  modport master (output rx_valid, rx_data, input rx_ready, prog_en, prog_addr, prog_data);
  modport slave (input rx_valid, rx_data, output rx_ready, prog_en, prog_addr, prog_data);
endinterface

// File: rtl/riscv_boot_sequencer.sv
// riscv_boot_sequencer: loads a length-prefixed LE word image into imem, then releases the core (optional checksum: BOOT_CHECKSUM_EN)
module riscv_boot_sequencer #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 4096,
  parameter int          TIMEOUT_CYCLES = 65536,
  parameter int          HOLD_CYCLES    = 4
) (
  input  logic                   clk,
  input  logic                   start,
  riscv_boot_sequencer_if.slave  bus,
  output logic                   core_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [2:0] {
    HDR, DATA,
`ifdef BOOT_CHECKSUM_EN
    CSUM,
`endif
    HOLD, RUN, ERR
  } state_t;
  state_t        state, state_nx;
  logic [1:0]    lane;
  logic [23:0]   buffer;
  logic [IW-1:0] n, idx;
  logic [TW-1:0] idle;
  logic [HW-1:0] hold_cnt;
  logic          started;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   sum;
`endif
  logic          loading, rdy, acc, word_done, hdr_bad, last, timeout, hold_end;
  logic [31:0]   word;
`ifdef BOOT_CHECKSUM_EN
  assign loading = state == DATA || state == CSUM;
`else
  assign loading = state == DATA;
`endif
  assign rdy       = state == HDR || loading;
  assign acc       = bus.rx_valid && rdy;
  assign word      = {bus.rx_data, buffer};
  assign word_done = acc && lane == 2'd3;
  assign hdr_bad   = word == 32'd0 || word > 32'(MAX_WORDS);
  assign last      = idx == n - IW'(1);
  assign timeout   = busy && !acc && idle == TW'(TIMEOUT_CYCLES - 1);
  assign hold_end  = hold_cnt == HW'(HOLD_CYCLES - 1);
  // state register, cleared by the core-facing start/reset
  always_ff @(posedge clk) begin
    state <= start ? HDR : state_nx;
  end
  // next state: a completed word or an idle timeout drives every transition out of the load states
  always_comb begin
    state_nx = state;
    case (state)
      HDR:  state_nx = word_done ? (hdr_bad ? ERR : DATA) : timeout ? ERR : HDR;
`ifdef BOOT_CHECKSUM_EN
      DATA: state_nx = word_done && last ? CSUM : timeout ? ERR : DATA;
      CSUM: state_nx = word_done ? (word == sum ? HOLD : ERR) : timeout ? ERR : CSUM;
`else
      DATA: state_nx = word_done && last ? HOLD : timeout ? ERR : DATA;
`endif
      HOLD: state_nx = hold_end ? RUN : HOLD;
      default: state_nx = state;
    endcase
  end
  // outputs depend on state only, so rx_ready never loops back through rx_valid
  always_comb begin
    bus.rx_ready = rdy;
    busy         = loading || (state == HDR && started);
    core_hold    = state != RUN;
    done         = state == RUN;
    error        = state == ERR;
  end
  // datapath: byte assembly, word/idle/hold counters and the registered programming write
  always_ff @(posedge clk) begin
    if (start) begin
      lane          <= '0;
      buffer        <= '0;
      n             <= '0;
      idx           <= '0;
      idle          <= '0;
      hold_cnt      <= '0;
      started       <= 1'b0;
      bus.prog_en   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      bus.prog_en <= word_done && state == DATA;
      idle        <= (acc || !busy) ? '0 : idle + TW'(1);
      hold_cnt    <= state == HOLD ? hold_cnt + HW'(1) : '0;
      if (acc) begin
        lane   <= lane + 2'd1;
        buffer <= {bus.rx_data, buffer[23:8]};
      end
      if (acc && state == HDR) started <= 1'b1;
      if (word_done && state == HDR) begin
        n   <= word[IW-1:0];
        idx <= '0;
      end
      if (word_done && state == DATA) begin
        idx           <= idx + IW'(1);
        bus.prog_addr <= BASE_ADDR + 32'({idx, 2'b00});
        bus.prog_data <= word;
`ifdef BOOT_CHECKSUM_EN
        sum           <= sum + word;
`endif
      end
    end
  end
endmodule
